// File: rtl/input_writer_pkg.sv
// Shared types and constants for the switch-input capture block.
package input_writer_pkg;

    localparam int unsigned DEBOUNCE_DEFAULT = 20000;
    localparam int unsigned DEBOUNCE_SIM     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser and debouncer; emits a single-cycle pulse on the edge
// where the debounced level rises.
module btn_debounce
    import input_writer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             btn_sync;
    logic [CNT_W-1:0] cnt_q;
    logic             settle_c;

    assign btn_sync = sync_q[1];

    // Level flips on this edge only after CNT_LAST consecutive differing cycles.
    assign settle_c = (btn_sync != level_o) && (cnt_q == CNT_LAST);
    assign rise_c   = settle_c && btn_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            if (btn_sync == level_o) begin
                cnt_q <= '0;
            end else if (settle_c) begin
                level_o <= btn_sync;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/input_writer.sv
// Captures the board switches on a debounced button press and hands the
// extended word to the CPU over a req/valid/ack handshake.
module input_writer
    import input_writer_pkg::*;
#(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned SW_W            = 16,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw_i,
    input  logic              btn_i,
    input  logic              req_i,
    input  logic              sign_ext_i,
    input  logic              ack_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              waiting_o
);

    state_t              state_q;
    logic [SW_W-1:0]     sw_meta_q;
    logic [SW_W-1:0]     sw_sync_q;
    logic                sign_ext_q;
    logic                btn_level;
    logic                btn_rise_c;
    logic [DATA_W-1:0]   sw_ext_c;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_i),
        .level_o(btn_level),
        .rise_c (btn_rise_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_comb begin
        sw_ext_c = DATA_W'(sw_sync_q);
        if (sign_ext_q) begin
            sw_ext_c = DATA_W'($signed(sw_sync_q));
        end
    end

    // Status outputs are registered alongside the state so they never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sign_ext_q <= 1'b0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            waiting_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        state_q    <= ARMED;
                        sign_ext_q <= sign_ext_i;
                        waiting_o  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (btn_rise_c) begin
                        state_q   <= HOLD;
                        data_o    <= sw_ext_c;
                        valid_o   <= 1'b1;
                        waiting_o <= 1'b0;
                    end
                end
                HOLD: begin
                    if (ack_i) begin
                        state_q <= RELEASE;
                        valid_o <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!btn_level) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    valid_o   <= 1'b0;
                    waiting_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_writer.sv
// Directed bench for input_writer with a short debounce window.
module tb_input_writer;
    import input_writer_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SW_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [SW_W-1:0]   sw_i = '0;
    logic              btn_i = 1'b0;
    logic              req_i = 1'b0;
    logic              sign_ext_i = 1'b0;
    logic              ack_i = 1'b0;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              waiting_o;

    int checks = 0;
    int failures = 0;

    input_writer #(
        .DATA_W         (DATA_W),
        .SW_W           (SW_W),
        .DEBOUNCE_CYCLES(DEBOUNCE_SIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_i      (sw_i),
        .btn_i     (btn_i),
        .req_i     (req_i),
        .sign_ext_i(sign_ext_i),
        .ack_i     (ack_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .waiting_o (waiting_o)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_i = ~btn_i;
            sw_i  = ~sw_i;
            #4;
            if (data_o !== '0 || valid_o !== 1'b0 || waiting_o !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_hold data=%h valid=%b waiting=%b exp 0/0/0", data_o, valid_o, waiting_o);
        end
        #3;
        rst   = 1'b1;
        btn_i = 1'b0;
        sw_i  = '0;
        tick(4);
        checks++;
        if (valid_o !== 1'b0 || waiting_o !== 1'b0 || data_o !== '0) begin
            failures++;
            $display("FAIL reset_idle data=%h valid=%b waiting=%b exp 0/0/0", data_o, valid_o, waiting_o);
        end
    endtask

    task automatic test_capture(input logic sx, input logic [SW_W-1:0] sw, input logic [DATA_W-1:0] exp);
        sw_i       = sw;
        sign_ext_i = sx;
        req_i      = 1'b1;
        tick(1);
        req_i      = 1'b0;
        sign_ext_i = ~sx;
        checks++;
        if (waiting_o !== 1'b1) begin
            failures++;
            $display("FAIL cap_waiting got=%b exp=1", waiting_o);
        end
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || waiting_o !== 1'b1) begin
            failures++;
            $display("FAIL ack_in_armed valid=%b waiting=%b exp 0/1", valid_o, waiting_o);
        end
        btn_i = 1'b1;
        tick(5);
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL cap_early got valid=%b exp=0", valid_o);
        end
        tick(1);
        checks++;
        if (valid_o !== 1'b1 || data_o !== exp || waiting_o !== 1'b0) begin
            failures++;
            $display("FAIL cap_word valid=%b data=%h waiting=%b exp 1/%h/0", valid_o, data_o, waiting_o, exp);
        end
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || data_o !== exp) begin
            failures++;
            $display("FAIL cap_ack valid=%b data=%h exp 0/%h", valid_o, data_o, exp);
        end
        req_i = 1'b1;
        tick(2);
        req_i = 1'b0;
        checks++;
        if (waiting_o !== 1'b0) begin
            failures++;
            $display("FAIL req_in_release waiting=%b exp=0", waiting_o);
        end
        btn_i = 1'b0;
        tick(7);
        checks++;
        if (waiting_o !== 1'b0 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL cap_idle waiting=%b valid=%b exp 0/0", waiting_o, valid_o);
        end
    endtask

    task automatic test_bounce;
        bit early;
        early      = 1'b0;
        sw_i       = 16'h1234;
        sign_ext_i = 1'b0;
        req_i      = 1'b1;
        tick(1);
        req_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_i = 1'b1;
            tick((i % 3) + 1);
            if (valid_o !== 1'b0) early = 1'b1;
            btn_i = 1'b0;
            tick(1 + (i % 2));
            if (valid_o !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            failures++;
            $display("FAIL bounce_capture got valid=1 during bounces exp=0");
        end
        btn_i = 1'b1;
        tick(5);
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL bounce_early got valid=%b exp=0", valid_o);
        end
        tick(1);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'h0000_1234) begin
            failures++;
            $display("FAIL bounce_word valid=%b data=%h exp 1/00001234", valid_o, data_o);
        end
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        btn_i = 1'b0;
        tick(8);
    endtask

    task automatic test_held_before_req;
        btn_i = 1'b1;
        tick(8);
        sw_i       = 16'hFF00;
        sign_ext_i = 1'b1;
        req_i      = 1'b1;
        tick(1);
        req_i = 1'b0;
        tick(10);
        checks++;
        if (valid_o !== 1'b0 || waiting_o !== 1'b1) begin
            failures++;
            $display("FAIL held_no_capture valid=%b waiting=%b exp 0/1", valid_o, waiting_o);
        end
        btn_i = 1'b0;
        tick(8);
        checks++;
        if (valid_o !== 1'b0 || waiting_o !== 1'b1) begin
            failures++;
            $display("FAIL held_release valid=%b waiting=%b exp 0/1", valid_o, waiting_o);
        end
        btn_i = 1'b1;
        tick(6);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'hFFFF_FF00) begin
            failures++;
            $display("FAIL held_repress valid=%b data=%h exp 1/ffffff00", valid_o, data_o);
        end
    endtask

    task automatic test_hold_ignore;
        btn_i = 1'b0;
        tick(8);
        sw_i  = 16'h5555;
        btn_i = 1'b1;
        tick(8);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'hFFFF_FF00) begin
            failures++;
            $display("FAIL hold_ignore valid=%b data=%h exp 1/ffffff00", valid_o, data_o);
        end
    endtask

    task automatic test_reset_in_hold;
        #5;
        rst = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || data_o !== '0 || waiting_o !== 1'b0) begin
            failures++;
            $display("FAIL async_reset valid=%b data=%h waiting=%b exp 0/0/0", valid_o, data_o, waiting_o);
        end
        tick(1);
        #3;
        rst = 1'b1;
        tick(10);
        sw_i       = 16'h0001;
        sign_ext_i = 1'b0;
        req_i      = 1'b1;
        tick(1);
        req_i = 1'b0;
        tick(10);
        checks++;
        if (valid_o !== 1'b0 || waiting_o !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_no_capture valid=%b waiting=%b exp 0/1", valid_o, waiting_o);
        end
        btn_i = 1'b0;
        tick(8);
        btn_i = 1'b1;
        tick(6);
        checks++;
        if (valid_o !== 1'b1 || data_o !== 32'h0000_0001) begin
            failures++;
            $display("FAIL post_reset_capture valid=%b data=%h exp 1/00000001", valid_o, data_o);
        end
    endtask

    initial begin
        test_reset;
        test_capture(1'b0, 16'h8001, 32'h0000_8001);
        test_capture(1'b1, 16'h8001, 32'hFFFF_8001);
        test_bounce;
        test_held_before_req;
        test_hold_ignore;
        test_reset_in_hold;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
